tomasulo_rs: RTL and testbench

TOMASULO_RS -- requirements
Module: tomasulo_rs

---
 rtl/tomasulo_rs.sv | 217 +++++++++++++++++++++
 tb/tb_tomasulo_rs.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_rs.sv
// tomasulo_pkg / tomasulo_rs
//
// Reservation station for a Tomasulo-style out-of-order core.
// Holds N pending operations, snoops the registered CDB for operand
// wakeup and issues the lowest-index ready entry to execute, one per cycle.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst_n          synchronous active-low reset
//   disp_vld       dispatch request
//   disp_rdy       at least one free entry (registered state only)
//   disp_op        operation
//   disp_src_vld   per-source data-present flag
//   disp_src_data  per-source data (used where disp_src_vld[i]=1)
//   disp_src_tag   per-source producer tag (used where disp_src_vld[i]=0)
//   disp_imm/disp_robid/disp_wa/disp_tag  immediate, ROB id, write address, dest tag
//   cdb_r          registered result bus (snooped)
//   iss_vld        registered issue valid (no backpressure)
//   iss            registered issue payload
//
// Configuration:
//   TOMASULO_RS_WAKEUP_BYPASS_EN  when defined, selection also treats sources
//   matched by cdb_r in the current cycle as ready and forwards cdb_r.wdata
//   into the issue payload (CDB at T -> issue at T+1 instead of T+2).

package tomasulo_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SLT = 4'd7
    } opcode_t;

    typedef logic [31:0] word_t;
    typedef logic [15:0] imm_t;
    typedef logic [3:0]  tag_t;
    typedef logic [3:0]  robid_t;
    typedef logic [4:0]  wa_t;

    typedef struct packed {
        opcode_t      op;
        word_t [1:0]  rdata;
        imm_t         imm;
        tag_t         tag;
        robid_t       robid;
        wa_t          wa;
    } issue_t;

    typedef struct packed {
        logic  vld;
        tag_t  tag;
        word_t wdata;
    } cdb_t;

endpackage

module tomasulo_rs
    import tomasulo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         disp_vld,
    output logic         disp_rdy,
    input  opcode_t      disp_op,
    input  logic [1:0]   disp_src_vld,
    input  word_t [1:0]  disp_src_data,
    input  tag_t [1:0]   disp_src_tag,
    input  imm_t         disp_imm,
    input  robid_t       disp_robid,
    input  wa_t          disp_wa,
    input  tag_t         disp_tag,
    input  cdb_t         cdb_r,
    output logic         iss_vld,
    output issue_t       iss
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Entry storage
    logic [N-1:0] valid;
    opcode_t      op_q     [N];
    imm_t         imm_q    [N];
    tag_t         tag_q    [N];
    robid_t       robid_q  [N];
    wa_t          wa_q     [N];
    logic [1:0]   src_rdy  [N];
    word_t        src_data [N][2];
    tag_t         src_tag  [N][2];

    logic          disp_fire;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] sel_idx;
    logic          sel_vld;
    logic [N-1:0]  elig;
    logic [1:0]    cdb_hit  [N];
    logic [1:0]    disp_hit;
    word_t [1:0]   iss_rdata;

    assign disp_rdy  = ~&valid;
    assign disp_fire = disp_vld & disp_rdy;

    // Lowest-index free entry (descending scan so the lowest wins).
    always_comb begin
        free_idx = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (!valid[i-1]) free_idx = IW'(i - 1);
        end
    end

    // CDB tag match for each waiting source of each valid entry.
    always_comb begin
        cdb_hit = '{default: '0};
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                cdb_hit[i][s] = cdb_r.vld && valid[i] && !src_rdy[i][s] &&
                                (src_tag[i][s] == cdb_r.tag);
            end
        end
    end

    // CDB match on a source that arrives without data in the dispatch cycle.
    always_comb begin
        disp_hit = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            disp_hit[s] = !disp_src_vld[s] && cdb_r.vld &&
                          (disp_src_tag[s] == cdb_r.tag);
        end
    end

    // Eligibility: entries dispatched this cycle are not yet valid, so they
    // can never be picked in their own dispatch cycle.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N; i++) begin
`ifdef TOMASULO_RS_WAKEUP_BYPASS_EN
            elig[i] = valid[i] && (&(src_rdy[i] | cdb_hit[i]));
`else
            elig[i] = valid[i] && (&src_rdy[i]);
`endif
        end
    end

    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (elig[i-1]) begin
                sel_idx = IW'(i - 1);
                sel_vld = 1'b1;
            end
        end
    end

    // Operand read for the selected entry, with optional CDB forwarding.
    always_comb begin
        iss_rdata = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            iss_rdata[s] = src_data[sel_idx][s];
`ifdef TOMASULO_RS_WAKEUP_BYPASS_EN
            if (cdb_hit[sel_idx][s]) iss_rdata[s] = cdb_r.wdata;
`endif
        end
    end

    // Selection only touches valid entries and dispatch only free ones, so
    // the two index writes below never target the same entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= '0;
            iss_vld <= 1'b0;
            iss     <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned s = 0; s < 2; s++) begin
                    if (cdb_hit[i][s]) begin
                        src_rdy[i][s]  <= 1'b1;
                        src_data[i][s] <= cdb_r.wdata;
                    end
                end
            end

            if (sel_vld) valid[sel_idx] <= 1'b0;

            if (disp_fire) begin
                valid[free_idx]   <= 1'b1;
                op_q[free_idx]    <= disp_op;
                imm_q[free_idx]   <= disp_imm;
                tag_q[free_idx]   <= disp_tag;
                robid_q[free_idx] <= disp_robid;
                wa_q[free_idx]    <= disp_wa;
                for (int unsigned s = 0; s < 2; s++) begin
                    src_rdy[free_idx][s]  <= disp_src_vld[s] | disp_hit[s];
                    src_data[free_idx][s] <= disp_src_vld[s] ? disp_src_data[s] : cdb_r.wdata;
                    src_tag[free_idx][s]  <= disp_src_tag[s];
                end
            end

            iss_vld <= sel_vld;
            if (sel_vld) begin
                iss.op    <= op_q[sel_idx];
                iss.rdata <= iss_rdata;
                iss.imm   <= imm_q[sel_idx];
                iss.tag   <= tag_q[sel_idx];
                iss.robid <= robid_q[sel_idx];
                iss.wa    <= wa_q[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_tomasulo_rs.sv
// Testbench for tomasulo_rs. Directed steps; expected issue payloads are
// queued when stimulus is driven and popped when iss_vld is sampled.
// Honours TOMASULO_RS_WAKEUP_BYPASS_EN for wakeup latency expectations.

module tb_tomasulo_rs;
    import tomasulo_pkg::*;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         disp_vld;
    logic         disp_rdy;
    opcode_t      disp_op;
    logic [1:0]   disp_src_vld;
    word_t [1:0]  disp_src_data;
    tag_t [1:0]   disp_src_tag;
    imm_t         disp_imm;
    robid_t       disp_robid;
    wa_t          disp_wa;
    tag_t         disp_tag;
    cdb_t         cdb_r;
    logic         iss_vld;
    issue_t       iss;

    issue_t exp_q[$];
    issue_t last_iss;
    int     n_checks;
    int     n_fail;

    tomasulo_rs #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .disp_vld      (disp_vld),
        .disp_rdy      (disp_rdy),
        .disp_op       (disp_op),
        .disp_src_vld  (disp_src_vld),
        .disp_src_data (disp_src_data),
        .disp_src_tag  (disp_src_tag),
        .disp_imm      (disp_imm),
        .disp_robid    (disp_robid),
        .disp_wa       (disp_wa),
        .disp_tag      (disp_tag),
        .cdb_r         (cdb_r),
        .iss_vld       (iss_vld),
        .iss           (iss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic issue_t mk(opcode_t op, word_t r1, word_t r0, imm_t imm,
                                  tag_t tag, robid_t robid, wa_t wa);
        issue_t r;
        r.op       = op;
        r.rdata[1] = r1;
        r.rdata[0] = r0;
        r.imm      = imm;
        r.tag      = tag;
        r.robid    = robid;
        r.wa       = wa;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    task automatic chk_iss(input string name, input issue_t obs, input issue_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Check iss_vld; on an expected issue pop the scoreboard and compare the
    // payload, otherwise check that iss holds the last issued value.
    task automatic sample(input string name, input logic exp_vld);
        issue_t e;
        chk1({name, "_vld"}, iss_vld, exp_vld);
        if (exp_vld) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL %s_sb: observed empty scoreboard expected pending entry", name);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_iss(name, iss, e);
                last_iss = e;
            end
        end else begin
            chk_iss({name, "_hold"}, iss, last_iss);
        end
    endtask

    task automatic disp_set(input opcode_t op, input logic [1:0] sv,
                            input word_t d1, input word_t d0,
                            input tag_t t1, input tag_t t0,
                            input imm_t imm, input tag_t tag,
                            input robid_t robid, input wa_t wa);
        disp_vld         = 1'b1;
        disp_op          = op;
        disp_src_vld     = sv;
        disp_src_data[1] = d1;
        disp_src_data[0] = d0;
        disp_src_tag[1]  = t1;
        disp_src_tag[0]  = t0;
        disp_imm         = imm;
        disp_tag         = tag;
        disp_robid       = robid;
        disp_wa          = wa;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        last_iss      = '0;
        rst_n         = 1'b0;
        disp_vld      = 1'b0;
        disp_op       = OP_ADD;
        disp_src_vld  = '0;
        disp_src_data = '0;
        disp_src_tag  = '0;
        disp_imm      = '0;
        disp_robid    = '0;
        disp_wa       = '0;
        disp_tag      = '0;
        cdb_r         = '0;

        // Reset state
        tick();
        tick();
        sample("rst", 1'b0);
        chk1("rst_disp_rdy", disp_rdy, 1'b1);
        rst_n = 1'b1;
        tick();
        sample("post_rst", 1'b0);
        chk1("post_rst_disp_rdy", disp_rdy, 1'b1);

        // Both sources present: issue on the edge after the entry is written
        disp_set(OP_AND, 2'b11, 32'h3C, 32'hF0, 4'd0, 4'd0, 16'h0012, 4'd3, 4'd1, 5'd2);
        exp_q.push_back(mk(OP_AND, 32'h3C, 32'hF0, 16'h0012, 4'd3, 4'd1, 5'd2));
        tick();
        disp_vld = 1'b0;
        sample("and_acc", 1'b0);
        tick();
        sample("and_iss", 1'b1);
        tick();
        sample("and_idle", 1'b0);

        // src0 waits on tag 5; unqualified CDB must not wake it
        disp_set(OP_ADD, 2'b10, 32'h11, 32'h0, 4'd0, 4'd5, 16'h0000, 4'd4, 4'd2, 5'd3);
        tick();
        disp_vld = 1'b0;
        sample("w5_acc", 1'b0);
        cdb_r = '{vld: 1'b0, tag: 4'd5, wdata: 32'hAA};
        for (int k = 0; k < 3; k++) begin
            tick();
            sample("novld", 1'b0);
        end
        cdb_r.vld = 1'b1;
        exp_q.push_back(mk(OP_ADD, 32'h11, 32'hAA, 16'h0000, 4'd4, 4'd2, 5'd3));
        tick();
        cdb_r = '0;
`ifdef TOMASULO_RS_WAKEUP_BYPASS_EN
        sample("wake_t1", 1'b1);
`else
        sample("wake_t1", 1'b0);
        tick();
        sample("wake_t2", 1'b1);
`endif
        tick();
        sample("wake_idle", 1'b0);

        // Fill all entries waiting on tag 7, then one CDB wakes them all
        for (int i = 0; i < N; i++) begin
            disp_set(OP_SUB, 2'b10, 32'h20 + 32'(i), 32'h0, 4'd0, 4'd7,
                     16'(i), 4'(8 + i), 4'(i), 5'(i));
            tick();
            sample("fill", 1'b0);
            chk1("fill_disp_rdy", disp_rdy, (i < N - 1) ? 1'b1 : 1'b0);
        end
        disp_set(OP_OR, 2'b11, 32'h1, 32'h1, 4'd0, 4'd0, 16'hFFFF, 4'd15, 4'd15, 5'd31);
        for (int k = 0; k < 2; k++) begin
            tick();
            sample("full_ign", 1'b0);
            chk1("full_disp_rdy", disp_rdy, 1'b0);
        end
        disp_vld = 1'b0;
        cdb_r = '{vld: 1'b1, tag: 4'd7, wdata: 32'h77};
        for (int i = 0; i < N; i++)
            exp_q.push_back(mk(OP_SUB, 32'h20 + 32'(i), 32'h77, 16'(i), 4'(8 + i), 4'(i), 5'(i)));
        tick();
        cdb_r = '0;
`ifndef TOMASULO_RS_WAKEUP_BYPASS_EN
        sample("fan_wait", 1'b0);
        tick();
`endif
        for (int k = 0; k < N; k++) begin
            sample("fan", 1'b1);
            if (k == 0) chk1("fan_disp_rdy", disp_rdy, 1'b1);
            tick();
        end
        sample("fan_done", 1'b0);

        // Wakeup captured in the dispatch cycle itself
        disp_set(OP_XOR, 2'b10, 32'h01, 32'h0, 4'd0, 4'd2, 16'h0000, 4'd6, 4'd5, 5'd7);
        cdb_r = '{vld: 1'b1, tag: 4'd2, wdata: 32'h55};
        exp_q.push_back(mk(OP_XOR, 32'h01, 32'h55, 16'h0000, 4'd6, 4'd5, 5'd7));
        tick();
        disp_vld = 1'b0;
        cdb_r = '0;
        sample("dcap_acc", 1'b0);
        tick();
        sample("dcap_iss", 1'b1);
        tick();
        sample("dcap_idle", 1'b0);

        // Dispatch concurrent with issue; freed entry reused next cycle
        disp_set(OP_ADD, 2'b11, 32'h2, 32'h1, 4'd0, 4'd0, 16'h0001, 4'd1, 4'd1, 5'd1);
        exp_q.push_back(mk(OP_ADD, 32'h2, 32'h1, 16'h0001, 4'd1, 4'd1, 5'd1));
        tick();
        disp_set(OP_OR, 2'b11, 32'h4, 32'h3, 4'd0, 4'd0, 16'h0002, 4'd2, 4'd2, 5'd2);
        exp_q.push_back(mk(OP_OR, 32'h4, 32'h3, 16'h0002, 4'd2, 4'd2, 5'd2));
        sample("a_acc", 1'b0);
        tick();
        disp_set(OP_AND, 2'b11, 32'h6, 32'h5, 4'd0, 4'd0, 16'h0003, 4'd10, 4'd3, 5'd3);
        exp_q.push_back(mk(OP_AND, 32'h6, 32'h5, 16'h0003, 4'd10, 4'd3, 5'd3));
        sample("a_iss", 1'b1);
        tick();
        disp_vld = 1'b0;
        sample("b_iss", 1'b1);
        tick();
        sample("c_iss", 1'b1);
        tick();
        sample("c_idle", 1'b0);

        // Reset mid-operation discards held entries
        for (int i = 0; i < 2; i++) begin
            disp_set(OP_SLT, 2'b10, 32'h9, 32'h0, 4'd0, 4'd9, 16'(i), 4'(11 + i), 4'(i), 5'(i));
            tick();
            sample("pre_rst", 1'b0);
        end
        disp_vld = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_iss = '0;
        sample("mid_rst", 1'b0);
        chk1("mid_rst_disp_rdy", disp_rdy, 1'b1);
        cdb_r = '{vld: 1'b1, tag: 4'd9, wdata: 32'h99};
        tick();
        cdb_r = '0;
        for (int k = 0; k < 3; k++) begin
            sample("no_stale", 1'b0);
            chk1("no_stale_disp_rdy", disp_rdy, 1'b1);
            tick();
        end

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
